branch_resolve: RTL

//  Downstream partner of the branch lookup table (BLT). Holds a FIFO of in-flight fetch predictions and

---
 rtl/branch_resolve_if.sv | 44 ++++
 rtl/branch_resolve.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// Fetch-side push port, execute-side resolve port and the BLT training / flush outputs of branch_resolve.
// The DUT connects through the slave modport; fetch/execute (or a bench) connects through master.
interface branch_resolve_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
);
    logic                   push;
    logic [ADDR_WIDTH-1:0]  push_pc;
    logic                   push_pred_taken;
    logic [ADDR_WIDTH-1:0]  push_pred_target;
    logic                   push_ready;

    logic                   resolve;
    logic [ADDR_WIDTH-1:0]  resolve_pc;
    logic                   resolve_taken;
    logic [ADDR_WIDTH-1:0]  resolve_target;

    logic                   blt_write;
    logic [ADDR_WIDTH-1:0]  blt_write_key;
    logic [ADDR_WIDTH-1:0]  blt_write_val;
    logic                   blt_hit;

    logic                   flush;
    logic [ADDR_WIDTH-1:0]  flush_pc;
    logic                   sync_error;
    logic [COUNT_WIDTH-1:0] branch_count;
    logic [COUNT_WIDTH-1:0] mispredict_count;

    modport master (
        output push, push_pc, push_pred_taken, push_pred_target,
        output resolve, resolve_pc, resolve_taken, resolve_target,
        input  push_ready,
        input  blt_write, blt_write_key, blt_write_val, blt_hit,
        input  flush, flush_pc, sync_error, branch_count, mispredict_count
    );

    modport slave (
        input  push, push_pc, push_pred_taken, push_pred_target,
        input  resolve, resolve_pc, resolve_taken, resolve_target,
        output push_ready,
        output blt_write, blt_write_key, blt_write_val, blt_hit,
        output flush, flush_pc, sync_error, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution unit: queues fetch-time predictions, checks them against execute outcomes,
// trains the BLT, raises a one-cycle redirect flush on a mispredict and keeps statistics.
module branch_resolve #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int DEPTH_LOG2  = 3,
    parameter int COUNT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
);
    localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH-1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // Prediction storage; contents are don't-care outside the occupied window, so no reset.
    logic [ADDR_WIDTH-1:0] pc_q     [DEPTH];
    logic                  taken_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] target_q [DEPTH];

    logic [DEPTH_LOG2-1:0] rd_q, rd_d;
    logic [DEPTH_LOG2-1:0] wr_q, wr_d;
    logic [DEPTH_LOG2:0]   occ_q, occ_d;

    logic                   blt_write_q;
    logic [ADDR_WIDTH-1:0]  blt_key_q;
    logic [ADDR_WIDTH-1:0]  blt_val_q;
    logic                   blt_hit_q;
    logic                   flush_q;
    logic [ADDR_WIDTH-1:0]  flush_pc_q, flush_pc_d;
    logic                   sync_error_q, sync_error_d;
    logic [COUNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [COUNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push_acc;
    logic                  head_taken;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  pc_mismatch;
    logic                  mispredict;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_FULL);
    assign pop   = bus.resolve && !empty;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc = bus.push && (!full || pop);

    // An empty FIFO resolves against a not-taken, target-0 default head.
    assign head_pc     = empty ? '0   : pc_q[rd_q];
    assign head_taken  = empty ? 1'b0 : taken_q[rd_q];
    assign head_target = empty ? '0   : target_q[rd_q];

    assign pc_mismatch = bus.resolve && (empty || (head_pc != bus.resolve_pc));
    assign mispredict  = bus.resolve &&
                         ((head_taken != bus.resolve_taken) ||
                          (head_taken && bus.resolve_taken && (head_target != bus.resolve_target)));

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        occ_d = occ_q;
        if (mispredict) begin
            rd_d  = '0;
            wr_d  = '0;
            occ_d = '0;
        end else begin
            if (pop) begin
                rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_ONE;
            end
            if (push_acc) begin
                wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_ONE;
            end
            if (push_acc && !pop) begin
                occ_d = occ_q + OCC_ONE;
            end else if (!push_acc && pop) begin
                occ_d = occ_q - OCC_ONE;
            end
        end
    end

    always_comb begin
        flush_pc_d         = flush_pc_q;
        sync_error_d       = sync_error_q | pc_mismatch;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (mispredict) begin
            flush_pc_d = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + PC_ONE;
        end
        if (bus.resolve && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + CNT_ONE;
        end
        if (mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            pc_q[wr_q]     <= bus.push_pc;
            taken_q[wr_q]  <= bus.push_pred_taken;
            target_q[wr_q] <= bus.push_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q               <= '0;
            wr_q               <= '0;
            occ_q              <= '0;
            blt_write_q        <= 1'b0;
            blt_key_q          <= '0;
            blt_val_q          <= '0;
            blt_hit_q          <= 1'b0;
            flush_q            <= 1'b0;
            flush_pc_q         <= '0;
            sync_error_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            rd_q               <= rd_d;
            wr_q               <= wr_d;
            occ_q              <= occ_d;
            blt_write_q        <= bus.resolve;
            flush_q            <= mispredict;
            flush_pc_q         <= flush_pc_d;
            sync_error_q       <= sync_error_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (bus.resolve) begin
                blt_key_q <= bus.resolve_pc;
                blt_val_q <= bus.resolve_target;
                blt_hit_q <= bus.resolve_taken;
            end
        end
    end

    assign bus.push_ready       = !full;
    assign bus.blt_write        = blt_write_q;
    assign bus.blt_write_key    = blt_key_q;
    assign bus.blt_write_val    = blt_val_q;
    assign bus.blt_hit          = blt_hit_q;
    assign bus.flush            = flush_q;
    assign bus.flush_pc         = flush_pc_q;
    assign bus.sync_error       = sync_error_q;
    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;
endmodule
